// File: rtl/alarm_sequencer.sv
// IR beam-break alarm sequencer: synchronized/debounced sensor, timed exit/entry/siren states.
// Optional tamper input enabled by defining ALARM_TAMPER_EN.
module alarm_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned EXIT_CYCLES     = 8,
    parameter int unsigned ENTRY_CYCLES    = 6,
    parameter int unsigned SIREN_CYCLES    = 10
) (
    input  logic       clk,
    input  logic       rstN,
    input  logic       irSensor,
`ifdef ALARM_TAMPER_EN
    input  logic       tamper,
`endif
    input  logic       armReq,
    input  logic       disarmReq,
    output logic       systemArmed,
    output logic       alarmActive,
    output logic       exitPending,
    output logic       entryPending,
    output logic [2:0] state
);

    localparam int unsigned MAX_AB  = (EXIT_CYCLES > ENTRY_CYCLES) ? EXIT_CYCLES : ENTRY_CYCLES;
    localparam int unsigned MAX_CYC = (MAX_AB > SIREN_CYCLES) ? MAX_AB : SIREN_CYCLES;
    localparam int unsigned TIMER_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int unsigned DEB_W   = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [TIMER_W-1:0] EXIT_LOAD  = TIMER_W'(EXIT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] ENTRY_LOAD = TIMER_W'(ENTRY_CYCLES - 1);
    localparam logic [TIMER_W-1:0] SIREN_LOAD = TIMER_W'(SIREN_CYCLES - 1);
    localparam logic [DEB_W-1:0]   DEB_FULL   = DEB_W'(DEBOUNCE_CYCLES);

    typedef enum logic [2:0] {
        StDisarmed   = 3'd0,
        StExitDelay  = 3'd1,
        StArmed      = 3'd2,
        StEntryDelay = 3'd3,
        StAlarm      = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [DEB_W-1:0]   deb_cnt_q;
    logic               ir_meta_q, ir_sync_q;
    logic               beam_broken;
    logic               timer_zero;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            ir_meta_q <= 1'b0;
            ir_sync_q <= 1'b0;
        end else begin
            ir_meta_q <= irSensor;
            ir_sync_q <= ir_meta_q;
        end
    end

    // Saturating run-length of high synchronized samples; any low sample restarts it.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            deb_cnt_q <= '0;
        end else if (!ir_sync_q) begin
            deb_cnt_q <= '0;
        end else if (deb_cnt_q != DEB_FULL) begin
            deb_cnt_q <= deb_cnt_q + 1'b1;
        end
    end

    assign beam_broken = (deb_cnt_q == DEB_FULL);
    assign timer_zero  = (timer_q == '0);

`ifdef ALARM_TAMPER_EN
    logic tamper_meta_q, tamper_sync_q;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            tamper_meta_q <= 1'b0;
            tamper_sync_q <= 1'b0;
        end else begin
            tamper_meta_q <= tamper;
            tamper_sync_q <= tamper_meta_q;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        timer_d = timer_zero ? '0 : timer_q - 1'b1;
        case (state_q)
            StDisarmed: begin
                if (armReq) begin
                    state_d = StExitDelay;
                    timer_d = EXIT_LOAD;
                end
            end
            StExitDelay: begin
                if (disarmReq) begin
                    state_d = StDisarmed;
                end else if (timer_zero) begin
                    state_d = StArmed;
                end
            end
            StArmed: begin
                if (disarmReq) begin
                    state_d = StDisarmed;
                end else if (beam_broken) begin
                    state_d = StEntryDelay;
                    timer_d = ENTRY_LOAD;
                end
            end
            StEntryDelay: begin
                if (disarmReq) begin
                    state_d = StDisarmed;
                end else if (timer_zero) begin
                    state_d = StAlarm;
                    timer_d = SIREN_LOAD;
                end
            end
            StAlarm: begin
                if (disarmReq) begin
                    state_d = StDisarmed;
                end else if (timer_zero) begin
                    if (beam_broken) begin
                        timer_d = SIREN_LOAD;
                    end else begin
                        state_d = StArmed;
                    end
                end
            end
            default: begin
                state_d = StDisarmed;
                timer_d = '0;
            end
        endcase
`ifdef ALARM_TAMPER_EN
        // Tamper overrides everything, including disarm, and pins the siren timer at reload.
        if (tamper_sync_q) begin
            state_d = StAlarm;
            timer_d = SIREN_LOAD;
        end
`endif
    end

    // Flags are registered from the next state so they switch on the same edge as state.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q      <= StDisarmed;
            timer_q      <= '0;
            systemArmed  <= 1'b0;
            alarmActive  <= 1'b0;
            exitPending  <= 1'b0;
            entryPending <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            systemArmed  <= (state_d == StArmed) || (state_d == StEntryDelay) ||
                            (state_d == StAlarm);
            alarmActive  <= (state_d == StAlarm);
            exitPending  <= (state_d == StExitDelay);
            entryPending <= (state_d == StEntryDelay);
        end
    end

    assign state = state_q;

endmodule
